pe_acc_drain: RTL and testbench



---
 rtl/pe_acc_drain.sv | 159 +++++++++++++++
 tb/tb_pe_acc_drain.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_acc_drain.sv
// Drain stage for one PE row: waits out the reduction/iteration length, captures the
// row accumulator on its valid cycle, saturates it to Q(INT_BW).(FRA_BW) and queues it for writeback.
module pe_acc_drain #(
    parameter int INT_BW   = 5,
    parameter int FRA_BW   = 10,
    parameter int MUL_BW   = 16,
    parameter int ACC_BW   = 32,
    parameter int CNT_BW   = 8,
    parameter int PIPE_LAT = 1,
    parameter int UNO_LAT  = 2,
    parameter int DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [CNT_BW-1:0] len,
    input  logic [ACC_BW-1:0] acc_i,
    output logic              busy,
    output logic [MUL_BW-1:0] res_o,
    output logic              res_sat_o,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              ovf
);
    localparam int AW  = $clog2(DEPTH);
    localparam int TOP = INT_BW + 2 * FRA_BW;
    localparam logic [CNT_BW:0] ONE    = {{CNT_BW{1'b0}}, 1'b1};
    localparam logic [CNT_BW:0] LAT_GM = (CNT_BW + 1)'(PIPE_LAT);
    localparam logic [CNT_BW:0] LAT_UN = (CNT_BW + 1)'(UNO_LAT);
    localparam logic [AW:0]     FULL_N = (AW + 1)'(DEPTH);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t            state_reg, state_next;
    // One extra counter bit so len-1+LAT never wraps for the largest len.
    logic [CNT_BW:0]   cnt_reg, cnt_next;
    logic [CNT_BW:0]   target;
    logic [1:0]        mode_reg, mode_next;
    logic [CNT_BW-1:0] len_reg, len_next;
    logic              capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            mode_reg  <= '0;
            len_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
            len_reg   <= len_next;
        end
    end

    always_comb begin
        target = {1'b0, len_reg} + ((mode_reg == 2'b00) ? LAT_GM : LAT_UN) - ONE;
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;
        len_next   = len_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && (len != '0)) begin
                    mode_next  = mode;
                    len_next   = len;
                    cnt_next   = '0;
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (cnt_reg == target) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg == COUNT);

    // Value fits iff all bits above TOP replicate the sign; otherwise clamp by sign.
    logic [ACC_BW-1:TOP] acc_hi;
    logic                fits;
    logic [MUL_BW-1:0]   sat_res;
    logic                sat_flag;
    logic                unused_acc_lsbs;

    assign acc_hi          = acc_i[ACC_BW-1:TOP];
    assign fits            = (&acc_hi) | ~(|acc_hi);
    assign unused_acc_lsbs = ^acc_i[FRA_BW-1:0];

    always_comb begin
        sat_flag = ~fits;
        sat_res  = acc_i[TOP:FRA_BW];
        if (!fits) begin
            sat_res = acc_i[ACC_BW-1] ? {1'b1, {(MUL_BW - 1){1'b0}}}
                                      : {1'b0, {(MUL_BW - 1){1'b1}}};
        end
    end

    logic [MUL_BW:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]     count_reg, count_next;
    logic            ovf_reg;
    logic            full, pop, push, drop;

    assign full = (count_reg == FULL_N);
    assign pop  = res_valid & res_ready;
    // A pop on the same edge frees the slot the incoming result needs.
    assign push = capture & (~full | pop);
    assign drop = capture & full & ~pop;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr_reg] <= {sat_flag, sat_res};
                wr_ptr_reg      <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (drop) begin
                ovf_reg <= 1'b1;
            end
            count_reg <= count_next;
        end
    end

    assign {res_sat_o, res_o} = mem[rd_ptr_reg];
    assign res_valid          = (count_reg != '0);
    assign ovf                = ovf_reg;

endmodule

// File: tb/tb_pe_acc_drain.sv
// Scoreboard bench for pe_acc_drain: stimulus pushes expected results into a queue
// that models FIFO contents; a negedge monitor compares status and head/pops.
module tb_pe_acc_drain;
    localparam int INT_BW   = 5;
    localparam int FRA_BW   = 10;
    localparam int PIPE_LAT = 1;
    localparam int UNO_LAT  = 2;
    localparam int DEPTH    = 4;
    localparam int TOP      = INT_BW + 2 * FRA_BW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  len = 8'd0;
    logic [31:0] acc_i = 32'd0;
    logic        busy;
    logic [15:0] res_o;
    logic        res_sat_o;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        ovf;

    int          errors = 0;
    int          checks = 0;
    logic [16:0] q[$];
    logic        exp_busy = 1'b0;
    logic        exp_ovf = 1'b0;
    bit          mon_en = 1'b0;

    pe_acc_drain dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len), .acc_i(acc_i),
        .busy(busy), .res_o(res_o), .res_sat_o(res_sat_o), .res_valid(res_valid),
        .res_ready(res_ready), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: clamp to [-2^TOP, 2^TOP-1], then floor-divide by 2^FRA_BW.
    function automatic logic [16:0] model(input logic [31:0] a);
        longint v, maxa, mina, sh;
        v    = longint'($signed(a));
        maxa = (longint'(1) << TOP) - 1;
        mina = -(longint'(1) << TOP);
        if (v > maxa) return {1'b1, 16'h7FFF};
        if (v < mina) return {1'b1, 16'h8000};
        sh = v >>> FRA_BW;
        return {1'b0, 16'(sh)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_push(input logic [31:0] a);
        if (q.size() == DEPTH) begin
            exp_ovf = 1'b1;
            $display("drop: acc=%h (fifo full)", a);
        end else begin
            q.push_back(model(a));
        end
    endtask

    task automatic set_ready(input int rdy, input bit is_cap);
        case (rdy)
            1:       res_ready = 1'($urandom_range(0, 1));
            2:       res_ready = is_cap;
            default: ;
        endcase
    endtask

    // rdy: 0 keep res_ready, 1 random each cycle, 2 high only on the capture cycle.
    task automatic run_op(input logic [1:0] m, input int l, input logic [31:0] a,
                          input int rdy, input bit poke);
        int lat;
        lat   = (m == 2'b00) ? PIPE_LAT : UNO_LAT;
        start = 1'b1;
        mode  = m;
        len   = 8'(l);
        acc_i = $urandom;
        set_ready(rdy, 1'b0);
        tick();
        for (int c = 1; c <= l + lat; c++) begin
            start = poke && (c == 1);
            if (poke && c == 1) begin
                len  = 8'd3;
                mode = 2'($urandom_range(0, 3));
            end
            acc_i    = (c == l + lat) ? a : $urandom;
            exp_busy = 1'b1;
            set_ready(rdy, c == l + lat);
            tick();
        end
        start    = 1'b0;
        exp_busy = 1'b0;
        if (rdy == 2) res_ready = 1'b0;
        model_push(a);
    endtask

    task automatic do_reset();
        res_ready = 1'b0;
        start     = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        exp_busy = 1'b0;
        exp_ovf  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        res_ready = 1'b1;
        while (q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("res_valid", 32'(res_valid), 32'(q.size() != 0));
            chk("ovf", 32'(ovf), 32'(exp_ovf));
            if (res_valid && q.size() != 0) begin
                chk("res_o", 32'(res_o), 32'(q[0][15:0]));
                chk("res_sat_o", 32'(res_sat_o), 32'(q[0][16]));
                if (res_ready) begin
                    void'(q.pop_front());
                    $display("pop: res_o=%h sat=%b", res_o, res_sat_o);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sat_vals[4];
        logic [31:0] a;
        logic [31:0] r;
        sat_vals = '{32'h0400_0000, 32'hF000_0000, 32'h01FF_FFFF, 32'hFE00_0000};

        repeat (3) tick();
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_res_o", 32'(res_o), 32'd0);
        chk("reset_sat", 32'(res_sat_o), 32'd0);
        tick();

        res_ready = 1'b1;
        run_op(2'b00, 4, 32'h0000_0C00, 0, 1'b0);
        run_op(2'b10, 3, 32'h0000_8000, 0, 1'b0);
        foreach (sat_vals[i]) run_op(2'b00, 2, sat_vals[i], 0, 1'b0);
        drain();

        res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) run_op(2'b00, 1, 32'(i) << 10, 0, 1'b0);
        repeat (3) tick();
        drain();
        do_reset();

        res_ready = 1'b0;
        for (int i = 2; i <= 5; i++) run_op(2'b01, 1, 32'(i) << 10, 0, 1'b0);
        run_op(2'b11, 2, 32'h0000_7C00, 2, 1'b0);
        repeat (3) tick();
        drain();

        res_ready = 1'b1;
        start = 1'b1;
        len   = 8'd0;
        mode  = 2'b00;
        tick();
        start = 1'b0;
        repeat (4) tick();
        run_op(2'b00, 5, 32'h0001_2345, 0, 1'b1);
        drain();

        res_ready = 1'b0;
        run_op(2'b00, 1, 32'h0000_1400, 0, 1'b0);
        start = 1'b1;
        len   = 8'd6;
        mode  = 2'b00;
        tick();
        start    = 1'b0;
        exp_busy = 1'b1;
        tick();
        do_reset();
        res_ready = 1'b1;
        repeat (10) tick();

        for (int k = 0; k < 40; k++) begin
            r = $urandom;
            case ($urandom_range(0, 2))
                0:       a = r;
                1:       a = {{6{r[25]}}, r[25:0]};
                default: a = {{16{r[15]}}, r[15:0]};
            endcase
            run_op(2'($urandom_range(0, 3)), int'($urandom_range(1, 6)), a, 1,
                   1'($urandom_range(0, 1)));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
